cnn_rd_arbiter: RTL and testbench

Read-port arbiter for the CNN engine. Shares one memory read port between the CNN picture-data read client (`pic`) and weight read client (`wgt`). One transaction is outstanding at a time, and priority alternates round-robin. The block sits between the CNN datapath read requests and the memory-side read interface. It forwards the winner's address and size, returns read data to the owning client, and guards against a memory that never returns data.

---
 rtl/cnn_rd_arbiter.sv | 172 +++++++++++++++++
 tb/tb_cnn_rd_arbiter.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cnn_rd_arbiter.sv
// cnn_rd_arbiter: shares one memory read port between the CNN picture-data
// (pic) and weight (wgt) read clients. Only one transaction is outstanding at
// a time, and the clients take turns when both are requesting.
//
// Ports:
//   clk, rst_n                    clock, synchronous active-low reset
//   pic_req/start_addr/size_bytes picture client request (level, held to gnt)
//   pic_gnt, pic_data             one-cycle grant pulse with returned data
//   wgt_*                         same as pic_*, for the weight client
//   mem_req/start_addr/size_bytes request forwarded to memory
//   mem_gnt                       memory accepted the request
//   mem_rd_valid, mem_rd_data     one-cycle read data return
//   arb_busy                      transaction in progress (not IDLE)
//   arb_err                       sticky read-timeout flag, cleared by reset
module cnn_rd_arbiter #(
  parameter int ADDR_WIDTH      = 19,
  parameter int MEM_DATA_BUS    = 128,
  parameter int MAX_BYTES_TO_RD = 20,
  parameter int SIZE_W          = $clog2(MAX_BYTES_TO_RD) + 1,
  parameter int TIMEOUT_CYC     = 255
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    pic_req,
  input  logic [ADDR_WIDTH-1:0]   pic_start_addr,
  input  logic [SIZE_W-1:0]       pic_size_bytes,
  output logic                    pic_gnt,
  output logic [MEM_DATA_BUS-1:0] pic_data,
  input  logic                    wgt_req,
  input  logic [ADDR_WIDTH-1:0]   wgt_start_addr,
  input  logic [SIZE_W-1:0]       wgt_size_bytes,
  output logic                    wgt_gnt,
  output logic [MEM_DATA_BUS-1:0] wgt_data,
  output logic                    mem_req,
  output logic [ADDR_WIDTH-1:0]   mem_start_addr,
  output logic [SIZE_W-1:0]       mem_size_bytes,
  input  logic                    mem_gnt,
  input  logic                    mem_rd_valid,
  input  logic [MEM_DATA_BUS-1:0] mem_rd_data,
  output logic                    arb_busy,
  output logic                    arb_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_DATA,
    S_RESP,
    S_HOLD
  } state_t;

  localparam logic [SIZE_W-1:0] MAX_SIZE = SIZE_W'(MAX_BYTES_TO_RD);
  localparam logic [8:0]        TO_LIM   = 9'(TIMEOUT_CYC);

  state_t                  state_q, state_d;
  logic                    prio_q;      // 0: pic wins a tie, 1: wgt wins
  logic                    owner_q;     // 0: pic, 1: wgt
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [SIZE_W-1:0]       size_q;
  logic [7:0]              tcnt_q;
  logic                    err_q;
  logic [MEM_DATA_BUS-1:0] pic_data_q, wgt_data_q;

  logic                    win_wgt;
  logic [SIZE_W-1:0]       win_size_raw, win_size;
  logic [8:0]              tcnt_inc;
  logic                    latch, tcnt_clr, err_set, cap_en, cap_wgt;
  logic [MEM_DATA_BUS-1:0] cap_data;

  assign win_wgt      = wgt_req && (!pic_req || prio_q);
  assign win_size_raw = win_wgt ? wgt_size_bytes : pic_size_bytes;
  assign win_size     = (win_size_raw > MAX_SIZE) ? MAX_SIZE : win_size_raw;
  // Timeout fires on the cycle whose increment would reach the limit, so the
  // grant lands exactly TIMEOUT_CYC cycles after entering WAIT_DATA.
  assign tcnt_inc     = {1'b0, tcnt_q} + 9'd1;

  // Returned data is written straight into the owner's output register on the
  // transition into RESP, so it is visible during the grant cycle and then
  // simply holds until that client's next grant.
  always_comb begin
    state_d  = state_q;
    latch    = 1'b0;
    tcnt_clr = 1'b0;
    err_set  = 1'b0;
    cap_en   = 1'b0;
    cap_data = '0;
    cap_wgt  = (state_q == S_IDLE) ? win_wgt : owner_q;
    case (state_q)
      S_IDLE: begin
        if (pic_req || wgt_req) begin
          latch = 1'b1;
          if (win_size == '0) begin
            cap_en  = 1'b1;
            state_d = S_RESP;
          end else begin
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        if (mem_gnt) begin
          if (mem_rd_valid) begin
            cap_en   = 1'b1;
            cap_data = mem_rd_data;
            state_d  = S_RESP;
          end else begin
            tcnt_clr = 1'b1;
            state_d  = S_WAIT_DATA;
          end
        end
      end
      S_WAIT_DATA: begin
        if (mem_rd_valid) begin
          cap_en   = 1'b1;
          cap_data = mem_rd_data;
          state_d  = S_RESP;
        end else if (tcnt_inc == TO_LIM) begin
          cap_en  = 1'b1;
          err_set = 1'b1;
          state_d = S_RESP;
        end
      end
      S_RESP:  state_d = S_HOLD;
      S_HOLD:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      prio_q     <= 1'b0;
      owner_q    <= 1'b0;
      addr_q     <= '0;
      size_q     <= '0;
      tcnt_q     <= '0;
      err_q      <= 1'b0;
      pic_data_q <= '0;
      wgt_data_q <= '0;
    end else begin
      state_q <= state_d;
      if (latch) begin
        owner_q <= win_wgt;
        addr_q  <= win_wgt ? wgt_start_addr : pic_start_addr;
        size_q  <= win_size;
      end
      if (tcnt_clr)
        tcnt_q <= '0;
      else if (state_q == S_WAIT_DATA && tcnt_q != '1)
        tcnt_q <= tcnt_q + 8'd1;
      if (err_set)
        err_q <= 1'b1;
      if (cap_en) begin
        if (cap_wgt) wgt_data_q <= cap_data;
        else         pic_data_q <= cap_data;
      end
      if (state_q == S_RESP)
        prio_q <= ~owner_q;
    end
  end

  assign mem_req        = (state_q == S_ISSUE);
  assign mem_start_addr = addr_q;
  assign mem_size_bytes = size_q;
  assign pic_gnt        = (state_q == S_RESP) && !owner_q;
  assign wgt_gnt        = (state_q == S_RESP) &&  owner_q;
  assign pic_data       = pic_data_q;
  assign wgt_data       = wgt_data_q;
  assign arb_busy       = (state_q != S_IDLE);
  assign arb_err        = err_q;

endmodule

// File: tb/tb_cnn_rd_arbiter.sv
module tb_cnn_rd_arbiter;
  localparam int AW = 19;
  localparam int DW = 128;
  localparam int SW = 6;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          pic_req, wgt_req;
  logic [AW-1:0] pic_start_addr, wgt_start_addr;
  logic [SW-1:0] pic_size_bytes, wgt_size_bytes;
  logic          pic_gnt, wgt_gnt;
  logic [DW-1:0] pic_data, wgt_data;
  logic          mem_req;
  logic [AW-1:0] mem_start_addr;
  logic [SW-1:0] mem_size_bytes;
  logic          mem_gnt, mem_rd_valid;
  logic [DW-1:0] mem_rd_data;
  logic          arb_busy, arb_err;

  int n_cmp = 0;
  int n_bad = 0;

  cnn_rd_arbiter #(
    .ADDR_WIDTH(AW), .MEM_DATA_BUS(DW), .MAX_BYTES_TO_RD(20), .SIZE_W(SW), .TIMEOUT_CYC(255)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .pic_req(pic_req), .pic_start_addr(pic_start_addr), .pic_size_bytes(pic_size_bytes),
    .pic_gnt(pic_gnt), .pic_data(pic_data),
    .wgt_req(wgt_req), .wgt_start_addr(wgt_start_addr), .wgt_size_bytes(wgt_size_bytes),
    .wgt_gnt(wgt_gnt), .wgt_data(wgt_data),
    .mem_req(mem_req), .mem_start_addr(mem_start_addr), .mem_size_bytes(mem_size_bytes),
    .mem_gnt(mem_gnt), .mem_rd_valid(mem_rd_valid), .mem_rd_data(mem_rd_data),
    .arb_busy(arb_busy), .arb_err(arb_err)
  );

  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    pic_req = 1'b0; wgt_req = 1'b0;
    pic_start_addr = '0; wgt_start_addr = '0;
    pic_size_bytes = '0; wgt_size_bytes = '0;
    mem_gnt = 1'b0; mem_rd_valid = 1'b0; mem_rd_data = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  // One transaction for a lone requester, immediate memory response;
  // returns with the arbiter back in IDLE.
  task automatic run_simple(input bit is_wgt, input logic [AW-1:0] addr,
                            input logic [SW-1:0] size, input logic [DW-1:0] data);
    if (is_wgt) begin
      wgt_req = 1'b1; wgt_start_addr = addr; wgt_size_bytes = size;
    end else begin
      pic_req = 1'b1; pic_start_addr = addr; pic_size_bytes = size;
    end
    step();
    mem_gnt = 1'b1; mem_rd_valid = 1'b1; mem_rd_data = data;
    step();
    idle_inputs();
    step();
    step();
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if ({mem_req, pic_gnt, wgt_gnt, arb_busy, arb_err} !== 5'b0) begin
      n_bad++; $display("FAIL reset_flags: got %b expected 00000", {mem_req, pic_gnt, wgt_gnt, arb_busy, arb_err}); end
    n_cmp++; if (mem_start_addr !== '0 || mem_size_bytes !== '0) begin
      n_bad++; $display("FAIL reset_mem_fields: got addr %0h size %0d expected 0 0", mem_start_addr, mem_size_bytes); end
    n_cmp++; if (pic_data !== '0 || wgt_data !== '0) begin
      n_bad++; $display("FAIL reset_data: got pic %0h wgt %0h expected 0 0", pic_data, wgt_data); end
  endtask

  task automatic test_basic();
    do_reset();
    pic_req = 1'b1; pic_start_addr = 19'h100; pic_size_bytes = 6'd4;
    step();  // cycle 1
    n_cmp++; if (mem_req !== 1'b1 || mem_start_addr !== 19'h100 || mem_size_bytes !== 6'd4) begin
      n_bad++; $display("FAIL basic_issue: got req %b addr %0h size %0d expected 1 100 4", mem_req, mem_start_addr, mem_size_bytes); end
    n_cmp++; if (pic_gnt !== 1'b0 || wgt_gnt !== 1'b0) begin
      n_bad++; $display("FAIL basic_no_early_gnt: got pic %b wgt %b expected 0 0", pic_gnt, wgt_gnt); end
    mem_gnt = 1'b1; mem_rd_valid = 1'b1; mem_rd_data = 128'hA5;
    step();  // cycle 2
    n_cmp++; if (pic_gnt !== 1'b1 || pic_data !== 128'hA5 || wgt_gnt !== 1'b0) begin
      n_bad++; $display("FAIL basic_gnt: got pic_gnt %b data %0h wgt_gnt %b expected 1 a5 0", pic_gnt, pic_data, wgt_gnt); end
    idle_inputs();
    step();  // cycle 3, HOLD
    n_cmp++; if (pic_gnt !== 1'b0 || wgt_gnt !== 1'b0 || arb_busy !== 1'b1 || mem_req !== 1'b0) begin
      n_bad++; $display("FAIL basic_hold: got gnt %b%b busy %b req %b expected 00 1 0", pic_gnt, wgt_gnt, arb_busy, mem_req); end
    step();  // cycle 4, IDLE
    n_cmp++; if (arb_busy !== 1'b0 || pic_data !== 128'hA5) begin
      n_bad++; $display("FAIL basic_idle: got busy %b pic_data %0h expected 0 a5", arb_busy, pic_data); end
  endtask

  task automatic test_round_robin();
    int ngr = 0;
    int txn = 0;
    int lat = 0;
    bit prev_gnt = 1'b0;
    logic [DW-1:0] last_pic = '0;
    logic [DW-1:0] last_wgt = '0;
    do_reset();
    pic_req = 1'b1; pic_start_addr = 19'h111; pic_size_bytes = 6'd8;
    wgt_req = 1'b1; wgt_start_addr = 19'h222; wgt_size_bytes = 6'd16;
    for (int c = 0; c < 200 && ngr < 4; c++) begin
      step();
      if (pic_gnt || wgt_gnt) begin
        n_cmp++; if (pic_gnt !== (ngr % 2 == 0) || wgt_gnt !== (ngr % 2 == 1)) begin
          n_bad++; $display("FAIL rr_order[%0d]: got pic %b wgt %b expected pic %0d", ngr, pic_gnt, wgt_gnt, ngr % 2 == 0); end
        n_cmp++; if (prev_gnt !== 1'b0) begin
          n_bad++; $display("FAIL rr_one_cycle[%0d]: got consecutive grant expected single cycle", ngr); end
        if (pic_gnt) begin
          n_cmp++; if (pic_data !== 128'hD0 + DW'(ngr) || wgt_data !== last_wgt) begin
            n_bad++; $display("FAIL rr_data[%0d]: got pic %0h wgt %0h expected %0h %0h", ngr, pic_data, wgt_data, 128'hD0 + DW'(ngr), last_wgt); end
          last_pic = pic_data;
        end else begin
          n_cmp++; if (wgt_data !== 128'hD0 + DW'(ngr) || pic_data !== last_pic) begin
            n_bad++; $display("FAIL rr_data[%0d]: got wgt %0h pic %0h expected %0h %0h", ngr, wgt_data, pic_data, 128'hD0 + DW'(ngr), last_pic); end
          last_wgt = wgt_data;
        end
        ngr++;
        if (ngr == 4) begin pic_req = 1'b0; wgt_req = 1'b0; end
      end
      prev_gnt = pic_gnt || wgt_gnt;
      // Memory model: accept immediately, return data 3 cycles after accept.
      mem_rd_valid = 1'b0;
      if (lat != 0) begin
        lat--;
        if (lat == 0) begin
          mem_rd_valid = 1'b1; mem_rd_data = 128'hD0 + DW'(txn); txn++;
        end
      end
      mem_gnt = mem_req;
      if (mem_req) lat = 3;
    end
    n_cmp++; if (ngr != 4) begin
      n_bad++; $display("FAIL rr_count: got %0d grants expected 4 within budget", ngr); end
    idle_inputs();
    step(); step(); step();
  endtask

  task automatic test_size_limits();
    do_reset();
    run_simple(1'b0, 19'h40, 6'd4, 128'h55);
    wgt_req = 1'b1; wgt_start_addr = 19'h3000; wgt_size_bytes = 6'd25;
    step();
    n_cmp++; if (mem_req !== 1'b1 || mem_size_bytes !== 6'd20 || mem_start_addr !== 19'h3000) begin
      n_bad++; $display("FAIL clamp_size: got req %b size %0d addr %0h expected 1 20 3000", mem_req, mem_size_bytes, mem_start_addr); end
    mem_gnt = 1'b1; mem_rd_valid = 1'b1; mem_rd_data = 128'h77;
    step();
    n_cmp++; if (wgt_gnt !== 1'b1 || wgt_data !== 128'h77 || pic_gnt !== 1'b0) begin
      n_bad++; $display("FAIL clamp_gnt: got wgt_gnt %b data %0h pic_gnt %b expected 1 77 0", wgt_gnt, wgt_data, pic_gnt); end
    idle_inputs();
    step(); step();
    pic_req = 1'b1; pic_start_addr = 19'h500; pic_size_bytes = 6'd0;
    step();  // cycle 1
    n_cmp++; if (pic_gnt !== 1'b1 || pic_data !== '0 || mem_req !== 1'b0 || wgt_gnt !== 1'b0) begin
      n_bad++; $display("FAIL zero_size_gnt: got gnt %b data %0h mem_req %b wgt_gnt %b expected 1 0 0 0", pic_gnt, pic_data, mem_req, wgt_gnt); end
    pic_req = 1'b0;
    step();
    n_cmp++; if (mem_req !== 1'b0 || pic_gnt !== 1'b0 || arb_busy !== 1'b1) begin
      n_bad++; $display("FAIL zero_size_hold: got mem_req %b gnt %b busy %b expected 0 0 1", mem_req, pic_gnt, arb_busy); end
    step();
  endtask

  task automatic test_timeout();
    bit early = 1'b0;
    do_reset();
    run_simple(1'b0, 19'h80, 6'd4, 128'h99);
    pic_req = 1'b1; pic_start_addr = 19'h90; pic_size_bytes = 6'd8;
    step();  // ISSUE
    mem_gnt = 1'b1;
    step();  // first cycle in WAIT_DATA
    mem_gnt = 1'b0;
    n_cmp++; if (arb_err !== 1'b0 || arb_busy !== 1'b1) begin
      n_bad++; $display("FAIL timeout_pre: got err %b busy %b expected 0 1", arb_err, arb_busy); end
    for (int i = 1; i < 255; i++) begin
      step();
      if (pic_gnt || wgt_gnt) early = 1'b1;
    end
    n_cmp++; if (early !== 1'b0) begin
      n_bad++; $display("FAIL timeout_early: got grant before 255 cycles expected none"); end
    step();  // 255 cycles after entering WAIT_DATA
    n_cmp++; if (pic_gnt !== 1'b1 || pic_data !== '0 || arb_err !== 1'b1) begin
      n_bad++; $display("FAIL timeout_gnt: got gnt %b data %0h err %b expected 1 0 1", pic_gnt, pic_data, arb_err); end
    pic_req = 1'b0;
    step(); step();
    run_simple(1'b1, 19'hA0, 6'd4, 128'h42);
    n_cmp++; if (wgt_data !== 128'h42 || arb_err !== 1'b1) begin
      n_bad++; $display("FAIL err_sticky: got wgt_data %0h err %b expected 42 1", wgt_data, arb_err); end
    do_reset();
    n_cmp++; if (arb_err !== 1'b0) begin
      n_bad++; $display("FAIL err_reset: got %b expected 0", arb_err); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    run_simple(1'b0, 19'h10, 6'd4, 128'h33);  // leaves prio pointing at wgt
    pic_req = 1'b1; pic_start_addr = 19'h20; pic_size_bytes = 6'd4;
    step();
    mem_gnt = 1'b1;
    step();  // WAIT_DATA
    mem_gnt = 1'b0; pic_req = 1'b0;
    rst_n = 1'b0;
    step();
    n_cmp++; if ({mem_req, pic_gnt, wgt_gnt, arb_busy, arb_err} !== 5'b0 || pic_data !== '0 || mem_start_addr !== '0) begin
      n_bad++; $display("FAIL midreset_state: got flags %b pic_data %0h addr %0h expected 0 0 0",
                        {mem_req, pic_gnt, wgt_gnt, arb_busy, arb_err}, pic_data, mem_start_addr); end
    rst_n = 1'b1; mem_rd_valid = 1'b1; mem_rd_data = 128'hEE;
    step();
    mem_rd_valid = 1'b0;
    n_cmp++; if (pic_gnt !== 1'b0 || wgt_gnt !== 1'b0 || pic_data !== '0 || arb_busy !== 1'b0) begin
      n_bad++; $display("FAIL midreset_late_data: got gnt %b%b data %0h busy %b expected 00 0 0", pic_gnt, wgt_gnt, pic_data, arb_busy); end
    pic_req = 1'b1; pic_start_addr = 19'h300; pic_size_bytes = 6'd4;
    wgt_req = 1'b1; wgt_start_addr = 19'h400; wgt_size_bytes = 6'd4;
    step();
    n_cmp++; if (mem_req !== 1'b1 || mem_start_addr !== 19'h300) begin
      n_bad++; $display("FAIL midreset_prio: got req %b addr %0h expected 1 300", mem_req, mem_start_addr); end
    mem_gnt = 1'b1; mem_rd_valid = 1'b1; mem_rd_data = 128'h61;
    step();
    n_cmp++; if (pic_gnt !== 1'b1 || wgt_gnt !== 1'b0 || pic_data !== 128'h61) begin
      n_bad++; $display("FAIL midreset_next: got pic %b wgt %b data %0h expected 1 0 61", pic_gnt, wgt_gnt, pic_data); end
    idle_inputs();
    step(); step();
  endtask

  task automatic test_addr_change();
    do_reset();
    pic_req = 1'b1; pic_start_addr = 19'h100; pic_size_bytes = 6'd4;
    step();  // ISSUE, memory stalls
    pic_start_addr = 19'h200; pic_size_bytes = 6'd12;
    step();
    n_cmp++; if (mem_req !== 1'b1 || mem_start_addr !== 19'h100 || mem_size_bytes !== 6'd4) begin
      n_bad++; $display("FAIL addr_hold: got req %b addr %0h size %0d expected 1 100 4", mem_req, mem_start_addr, mem_size_bytes); end
    mem_gnt = 1'b1; mem_rd_valid = 1'b1; mem_rd_data = 128'hC3;
    step();
    n_cmp++; if (pic_gnt !== 1'b1 || pic_data !== 128'hC3) begin
      n_bad++; $display("FAIL addr_gnt: got gnt %b data %0h expected 1 c3", pic_gnt, pic_data); end
    idle_inputs();
    step(); step();  // back in IDLE
    mem_rd_valid = 1'b1; mem_rd_data = 128'hBAD;
    step();
    mem_rd_valid = 1'b0;
    n_cmp++; if (pic_gnt !== 1'b0 || wgt_gnt !== 1'b0 || arb_busy !== 1'b0 || pic_data !== 128'hC3 || wgt_data !== '0) begin
      n_bad++; $display("FAIL spurious_valid: got gnt %b%b busy %b pic %0h wgt %0h expected 00 0 c3 0",
                        pic_gnt, wgt_gnt, arb_busy, pic_data, wgt_data); end
    step();
    n_cmp++; if (pic_gnt !== 1'b0 || wgt_gnt !== 1'b0) begin
      n_bad++; $display("FAIL spurious_valid_late: got gnt %b%b expected 00", pic_gnt, wgt_gnt); end
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    test_reset();
    test_basic();
    test_round_robin();
    test_size_limits();
    test_timeout();
    test_reset_mid();
    test_addr_change();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
